// File: rtl/iceboard_pkg.sv
// iceboard_pkg: shared state encoding and constants for the ice board poll scheduler.
package iceboard_pkg;
  localparam int BOARD_ID_W = 4;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  typedef enum logic [2:0] {IDLE, SEND_HDR, SEND_ID, WAIT_RSP, GAP} state_e;
endpackage

// File: rtl/iceboard_rr_select.sv
// iceboard_rr_select: picks the next set mask bit after cur, wrapping to the lowest set bit.
module iceboard_rr_select
  import iceboard_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]            mask,
  input  logic [BOARD_ID_W-1:0]   cur,
  input  logic                    incl,
  output logic [BOARD_ID_W-1:0]   nxt,
  output logic                    any
);
  logic [BOARD_ID_W-1:0] lo, hi;
  logic hit;
  // Descending scan so the lowest qualifying index is written last.
  always_comb begin
    lo  = '0;
    hi  = '0;
    hit = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (mask[j]) lo = BOARD_ID_W'(j);
      if (mask[j] && (BOARD_ID_W'(j) > cur || (incl && BOARD_ID_W'(j) == cur))) begin
        hi  = BOARD_ID_W'(j);
        hit = 1'b1;
      end
    end
  end
  assign nxt = hit ? hi : lo;
  assign any = |mask;
endmodule

// File: rtl/iceboard_poll_scheduler.sv
// iceboard_poll_scheduler: round-robin UART poller for ice boards with timeout and online tracking.
// Optional per-board timeout statistics under ICEBOARD_POLL_STATS_EN.
module iceboard_poll_scheduler
  import iceboard_pkg::*;
#(
  parameter int         NUM_BOARDS     = 8,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         GAP_CYCLES     = 100,
  parameter int         MISS_LIMIT     = 3,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_BOARDS-1:0] board_mask,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic                  rx_done,
  input  logic [7:0]            rx_id,
  input  logic                  rx_crc_ok,
  output logic [3:0]            cur_board,
  output logic                  busy,
  output logic [NUM_BOARDS-1:0] board_online,
  output logic                  timeout_pulse,
`ifdef ICEBOARD_POLL_STATS_EN
  input  logic [3:0]            stat_sel,
  output logic [15:0]           stat_timeouts,
`endif
  output logic                  bad_frame_pulse
);
  localparam int CW = $clog2((TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES) + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BOARD_ID_W-1:0] cur_q, cur_d, nxt;
  logic [NUM_BOARDS-1:0] online_q, online_d;
  logic [MW-1:0] miss_q [NUM_BOARDS];
  logic [MW-1:0] miss_d [NUM_BOARDS];
  logic started_q, started_d, to_q, to_d, bad_q, bad_d;
  logic any, go, good, expire, miss;
  // Until the first poll after reset, board 0 itself is eligible so polling starts at the lowest set bit.
  iceboard_rr_select #(.N(NUM_BOARDS)) u_sel (
    .mask(board_mask),
    .cur (cur_q),
    .incl(!started_q),
    .nxt (nxt),
    .any (any)
  );
  assign go       = enable && any;
  assign good     = rx_done && rx_crc_ok && rx_id == 8'(cur_q);
  assign expire   = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign miss     = state_q == WAIT_RSP && expire && !good;
  assign tx_valid = state_q == SEND_HDR || state_q == SEND_ID;
  assign tx_data  = state_q == SEND_HDR ? SYNC_BYTE : state_q == SEND_ID ? 8'(cur_q) : 8'h00;
  assign busy     = state_q != IDLE;
  assign cur_board       = cur_q;
  assign board_online    = online_q;
  assign timeout_pulse   = to_q;
  assign bad_frame_pulse = bad_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    started_d = started_q || state_q == SEND_HDR;
    to_d      = 1'b0;
    bad_d     = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = go ? SEND_HDR : IDLE;
        cur_d   = go ? nxt : cur_q;
      end
      SEND_HDR: state_d = tx_ready ? SEND_ID : SEND_HDR;
      SEND_ID: begin
        state_d = tx_ready ? WAIT_RSP : SEND_ID;
        cnt_d   = '0;
      end
      WAIT_RSP: begin
        bad_d   = rx_done && !good;
        to_d    = miss;
        state_d = good || expire ? GAP : WAIT_RSP;
        cnt_d   = good || expire ? '0 : cnt_q + 1'b1;
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d = go ? SEND_HDR : IDLE;
          cur_d   = go ? nxt : cur_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    online_d = online_q;
    miss_d   = miss_q;
    for (int i = 0; i < NUM_BOARDS; i++) begin
      if (cur_q == BOARD_ID_W'(i) && state_q == WAIT_RSP && good) begin
        online_d[i] = 1'b1;
        miss_d[i]   = '0;
      end else if (cur_q == BOARD_ID_W'(i) && miss) begin
        miss_d[i]   = miss_q[i] == MW'(MISS_LIMIT) ? miss_q[i] : miss_q[i] + 1'b1;
        online_d[i] = miss_d[i] == MW'(MISS_LIMIT) ? 1'b0 : online_q[i];
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_q     <= '0;
      online_q  <= '0;
      miss_q    <= '{default: '0};
      started_q <= 1'b0;
      to_q      <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      online_q  <= online_d;
      miss_q    <= miss_d;
      started_q <= started_d;
      to_q      <= to_d;
      bad_q     <= bad_d;
    end
  end
`ifdef ICEBOARD_POLL_STATS_EN
  logic [15:0] stat_q [NUM_BOARDS];
  logic [15:0] stat_d [NUM_BOARDS];
  logic [15:0] stat_out_q, stat_out_d;
  always_comb begin
    stat_d     = stat_q;
    stat_out_d = '0;
    for (int i = 0; i < NUM_BOARDS; i++) begin
      if (miss && cur_q == BOARD_ID_W'(i) && stat_q[i] != 16'hFFFF) stat_d[i] = stat_q[i] + 1'b1;
      if (stat_sel == 4'(i)) stat_out_d = stat_q[i];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_q     <= '{default: '0};
      stat_out_q <= '0;
    end else begin
      stat_q     <= stat_d;
      stat_out_q <= stat_out_d;
    end
  end
  assign stat_timeouts = stat_out_q;
`endif
endmodule

// File: tb/tb_iceboard_poll_scheduler.sv
// tb_iceboard_poll_scheduler: table of whole-poll vectors plus directed stall, idle, reset and stats sequences.
module tb_iceboard_poll_scheduler;
  logic clock = 1'b0;
  logic reset, enable, tx_valid, tx_ready, rx_done, rx_crc_ok, busy, timeout_pulse, bad_frame_pulse;
  logic [7:0] board_mask, tx_data, rx_id, board_online;
  logic [3:0] cur_board;
`ifdef ICEBOARD_POLL_STATS_EN
  logic [3:0] stat_sel;
  logic [15:0] stat_timeouts;
`endif
  int n_vec = 0;
  int n_bad = 0;

  iceboard_poll_scheduler #(
    .NUM_BOARDS(8), .TIMEOUT_CYCLES(20), .GAP_CYCLES(4), .MISS_LIMIT(3)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .board_mask(board_mask),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_done(rx_done), .rx_id(rx_id), .rx_crc_ok(rx_crc_ok),
    .cur_board(cur_board), .busy(busy), .board_online(board_online),
    .timeout_pulse(timeout_pulse),
`ifdef ICEBOARD_POLL_STATS_EN
    .stat_sel(stat_sel), .stat_timeouts(stat_timeouts),
`endif
    .bad_frame_pulse(bad_frame_pulse)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] mask_next;
    int         rsp;
    int         dly;
    logic [3:0] board;
    logic [7:0] online;
  } vec_t;
  vec_t tbl [15];

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rx(input logic [7:0] id, input logic ok);
    rx_done = 1'b1;
    rx_id = id;
    rx_crc_ok = ok;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic wait_timeout(output int k);
    k = 0;
    while (!timeout_pulse && k < 100) begin tick(); k++; end
  endtask

  task automatic poll(input vec_t v);
    int k = 0;
    while (!tx_valid && k < 200) begin tick(); k++; end
    chk("hdr_valid", tx_valid, 1);
    chk("hdr_byte", tx_data, 8'hA5);
    board_mask = v.mask_next;
    tick();
    chk("id_byte", tx_data, {4'h0, v.board});
    chk("cur_board", cur_board, v.board);
    tick();
    if (v.rsp == 0) begin
      wait_timeout(k);
      chk("timeout_cycles", k, 20);
    end else begin
      if (v.rsp == 2) begin
        rx(8'h03, 1'b1);
        chk("bad_id_pulse", bad_frame_pulse, 1);
        rx({4'h0, v.board}, 1'b0);
        chk("bad_crc_pulse", bad_frame_pulse, 1);
        tick();
        chk("bad_pulse_clear", bad_frame_pulse, 0);
        chk("still_waiting", busy && !tx_valid, 1);
      end
      repeat (v.dly) tick();
      rx({4'h0, v.board}, 1'b1);
      chk("good_no_timeout", timeout_pulse, 0);
      chk("good_no_bad", bad_frame_pulse, 0);
    end
    chk("online", board_online, v.online);
    k = 0;
    while (!tx_valid && k < 50) begin tick(); k++; end
    chk("gap_cycles", k, 4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic stable;
    tbl[0]  = '{8'h05, 0, 0,  4'd0, 8'h00};
    tbl[1]  = '{8'h05, 1, 10, 4'd2, 8'h04};
    tbl[2]  = '{8'h05, 1, 3,  4'd0, 8'h05};
    tbl[3]  = '{8'h05, 0, 0,  4'd2, 8'h05};
    tbl[4]  = '{8'h05, 0, 0,  4'd0, 8'h05};
    tbl[5]  = '{8'h05, 1, 0,  4'd2, 8'h05};
    tbl[6]  = '{8'h05, 0, 0,  4'd0, 8'h05};
    tbl[7]  = '{8'h05, 0, 0,  4'd2, 8'h05};
    tbl[8]  = '{8'h02, 0, 0,  4'd0, 8'h04};
    tbl[9]  = '{8'h02, 2, 2,  4'd1, 8'h06};
    tbl[10] = '{8'h02, 0, 0,  4'd1, 8'h06};
    tbl[11] = '{8'h84, 0, 0,  4'd1, 8'h06};
    tbl[12] = '{8'h84, 1, 5,  4'd2, 8'h06};
    tbl[13] = '{8'h84, 0, 0,  4'd7, 8'h06};
    tbl[14] = '{8'h84, 0, 0,  4'd2, 8'h06};
    reset = 1'b1; enable = 1'b0; board_mask = 8'h00; tx_ready = 1'b1;
    rx_done = 1'b0; rx_id = 8'h00; rx_crc_ok = 1'b0;
`ifdef ICEBOARD_POLL_STATS_EN
    stat_sel = 4'd0;
`endif
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_cur_board", cur_board, 0);
    chk("rst_busy", busy, 0);
    chk("rst_online", board_online, 0);
    chk("rst_pulses", {timeout_pulse, bad_frame_pulse}, 0);
    board_mask = 8'h05;
    enable = 1'b1;
    tick();
    chk("busy_after_enable", busy, 1);
    for (int i = 0; i < 15; i++) poll(tbl[i]);

    tx_ready = 1'b0;
    stable = 1'b1;
    repeat (50) begin
      tick();
      if (!(tx_valid && tx_data == 8'hA5)) stable = 1'b0;
    end
    chk("hdr_stall_stable", stable, 1);
    tx_ready = 1'b1;
    tick();
    chk("id_after_stall", tx_data, 8'h07);
    tick();
    enable = 1'b0;
    wait_timeout(k);
    chk("drain_timeout_cycles", k, 20);
    k = 0;
    while (busy && k < 50) begin tick(); k++; end
    chk("gap_to_idle", k, 4);
    repeat (5) tick();
    chk("idle_busy", busy, 0);
    chk("idle_tx_valid", tx_valid, 0);

    rx(8'h07, 1'b1);
    chk("idle_rx_pulses", {timeout_pulse, bad_frame_pulse}, 0);
    rx(8'h03, 1'b0);
    chk("idle_rx_bad", bad_frame_pulse, 0);
    chk("idle_rx_online", board_online, 8'h06);

    enable = 1'b1;
    k = 0;
    while (!tx_valid && k < 50) begin tick(); k++; end
    tick();
    chk("pre_reset_id", tx_data, 8'h02);
    board_mask = 8'h81;
    reset = 1'b1;
    tick();
    chk("midreset_tx_valid", tx_valid, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_online", board_online, 0);
    chk("midreset_cur", cur_board, 0);
    reset = 1'b0;
    k = 0;
    while (!tx_valid && k < 50) begin tick(); k++; end
    chk("post_reset_hdr", tx_data, 8'hA5);
    tick();
    chk("post_reset_id", tx_data, 8'h00);

`ifdef ICEBOARD_POLL_STATS_EN
    reset = 1'b1;
    board_mask = 8'h10;
    tick();
    reset = 1'b0;
    for (int p = 0; p < 5; p++) begin
      k = 0;
      while (!tx_valid && k < 50) begin tick(); k++; end
      tick();
      tick();
      wait_timeout(k);
    end
    enable = 1'b0;
    stat_sel = 4'd4;
    tick();
    chk("stat_board4", stat_timeouts, 5);
    stat_sel = 4'd9;
    tick();
    chk("stat_out_of_range", stat_timeouts, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
